// File: rtl/rtmc_pkg.sv
// Shared definitions for the SPI-to-register-bus bridge: frame field positions,
// FSM state encoding and bus-timeout constants.
package rtmc_pkg;

   localparam int CMD_RD_BIT  = 31;
   localparam int ADDR_LSB    = 16;
   localparam int FRAME_BITS  = 32;
   localparam int TIMEOUT_VAL = 15;

   localparam logic [15:0] RD_TIMEOUT_DATA = 16'hDEAD;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_SHIFT_HDR  = 3'd1,
      ST_RD_REQ     = 3'd2,
      ST_SHIFT_DATA = 3'd3,
      ST_WR_REQ     = 3'd4,
      ST_DONE       = 3'd5
   } state_t;

endpackage

// File: rtl/rtmc_sync_edge.sv
// Multi-flop synchroniser with rise/fall detection on the synchronised level.
// RST_VAL sets the level the chain holds in reset (idle level of the pin).
module rtmc_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q[0] <= din;
         for (int i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/rtmc_spi_bridge.sv
// SPI mode-0 slave that turns 32-bit host frames into register-bus reads/writes.
// Optional bus timeout with sticky status bit: define RTMC_SPI_TIMEOUT_EN.
module rtmc_spi_bridge
   import rtmc_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_sclk,
   input  logic              spi_cs_n,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdat,
   output logic              reg_wr,
   output logic              reg_rd,
   input  logic [DATA_W-1:0] reg_rdat,
   input  logic              reg_ack,
   output logic              busy
);

   // Header occupies the first FRAME_BITS-DATA_W bits; the rx register holds
   // exactly one header, then exactly one data field.
   localparam logic [5:0] CNT_HDR      = 6'(FRAME_BITS - DATA_W);
   localparam logic [5:0] CNT_FULL     = 6'(FRAME_BITS);
   localparam logic [5:0] CNT_TX_SHIFT = CNT_HDR + 6'd1;
   localparam int         CMD_POS      = CMD_RD_BIT - DATA_W;
   localparam int         ADDR_POS     = ADDR_LSB - DATA_W;

   logic sclk_level, sclk_rise, sclk_fall;
   logic cs_level, cs_rise, cs_fall;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic mosi_bit;

   state_t state_q, state_d;
   logic [5:0]        bit_cnt_q;
   logic [DATA_W-1:0] rx_q;
   logic [DATA_W-1:0] tx_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdat_q;
   logic is_rd_q, miso_en_q, hdr_bit_q, pending_q, abort_q;

   logic start, shift_en, hdr_done, wr_go, req_done, rd_abort;
   logic req_active, to_expired, hdr_flag;

   rtmc_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (spi_sclk),
      .level (sclk_level),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   rtmc_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (spi_cs_n),
      .level (cs_level),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mosi_sync_q <= '0;
      end else begin
         mosi_sync_q[0] <= spi_mosi;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            mosi_sync_q[i] <= mosi_sync_q[i-1];
         end
      end
   end
   assign mosi_bit = mosi_sync_q[SYNC_STAGES-1];

   // A frame deferred behind a handshake starts only once SCLK is at its idle level.
   assign start      = (state_q == ST_IDLE) &&
                       (cs_fall || (pending_q && !cs_level && !sclk_level));
   assign shift_en   = sclk_rise && !cs_level && (state_q != ST_IDLE);
   assign hdr_done   = (state_q == ST_SHIFT_HDR) && !cs_level && (bit_cnt_q == CNT_HDR);
   assign wr_go      = (state_q == ST_SHIFT_DATA) && !cs_level && !is_rd_q &&
                       (bit_cnt_q == CNT_FULL);
   assign req_active = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
   assign req_done   = reg_ack || to_expired;
   assign rd_abort   = abort_q || cs_level;

`ifdef RTMC_SPI_TIMEOUT_EN
   logic [3:0] to_cnt_q;
   logic       to_flag_q;

   assign to_expired = req_active && !reg_ack && (to_cnt_q == 4'(TIMEOUT_VAL - 1));
   assign hdr_flag   = to_flag_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_q  <= '0;
         to_flag_q <= 1'b0;
      end else begin
         to_cnt_q <= req_active ? to_cnt_q + 4'd1 : 4'd0;
         if (to_expired) begin
            to_flag_q <= 1'b1;
         end else if (start) begin
            to_flag_q <= 1'b0;
         end
      end
   end
`else
   assign to_expired = 1'b0;
   assign hdr_flag   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:       if (start) state_d = ST_SHIFT_HDR;
         ST_SHIFT_HDR: begin
            if (cs_level)      state_d = ST_IDLE;
            else if (hdr_done) state_d = rx_q[CMD_POS] ? ST_RD_REQ : ST_SHIFT_DATA;
         end
         ST_RD_REQ:     if (req_done) state_d = rd_abort ? ST_IDLE : ST_SHIFT_DATA;
         ST_SHIFT_DATA: begin
            if (cs_level)   state_d = ST_IDLE;
            else if (wr_go) state_d = ST_WR_REQ;
         end
         ST_WR_REQ:     if (req_done) state_d = ST_DONE;
         ST_DONE:       if (cs_level || pending_q) state_d = ST_IDLE;
         default:       state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      reg_rd = (state_q == ST_RD_REQ);
      reg_wr = (state_q == ST_WR_REQ);
      busy   = (state_q != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_q <= '0;
         rx_q      <= '0;
         tx_q      <= '0;
         addr_q    <= '0;
         wdat_q    <= '0;
         is_rd_q   <= 1'b0;
         miso_en_q <= 1'b0;
         hdr_bit_q <= 1'b0;
         pending_q <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         if (state_q == ST_IDLE) begin
            bit_cnt_q <= '0;
         end else if (shift_en && bit_cnt_q != CNT_FULL) begin
            bit_cnt_q <= bit_cnt_q + 6'd1;
            rx_q      <= {rx_q[DATA_W-2:0], mosi_bit};
         end

         if (hdr_done) begin
            addr_q  <= rx_q[ADDR_POS +: ADDR_W];
            is_rd_q <= rx_q[CMD_POS];
         end
         if (wr_go) begin
            wdat_q <= rx_q;
         end

         // TX bit 15 is presented for the 17th rise, so shifting starts after it.
         if (state_q == ST_RD_REQ && req_done && !rd_abort) begin
            tx_q      <= reg_ack ? reg_rdat : DATA_W'(RD_TIMEOUT_DATA);
            miso_en_q <= 1'b1;
         end else if (state_q == ST_IDLE) begin
            miso_en_q <= 1'b0;
         end else if (sclk_fall && miso_en_q) begin
            if (bit_cnt_q == CNT_FULL) begin
               miso_en_q <= 1'b0;
            end else if (bit_cnt_q >= CNT_TX_SHIFT) begin
               tx_q <= {tx_q[DATA_W-2:0], 1'b0};
            end
         end

         if (start) begin
            hdr_bit_q <= hdr_flag;
         end else if (sclk_fall || state_q != ST_SHIFT_HDR) begin
            hdr_bit_q <= 1'b0;
         end

         if (state_q == ST_IDLE) begin
            if (start || cs_level) pending_q <= 1'b0;
         end else if (cs_fall) begin
            pending_q <= 1'b1;
         end

         abort_q <= (state_q == ST_RD_REQ) ? (abort_q | cs_rise) : 1'b0;
      end
   end

   assign reg_addr    = addr_q;
   assign reg_wdat    = wdat_q;
   assign spi_miso    = hdr_bit_q | (miso_en_q & tx_q[DATA_W-1]);
   assign spi_miso_oe = ~cs_level;

endmodule

// File: tb/tb_rtmc_spi_bridge.sv
// Directed bench for rtmc_spi_bridge: SPI host driver, responsive bus slave,
// bus monitor and immediate-assertion checks with a final result line.
module tb_rtmc_spi_bridge;

   localparam int HALF = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        spi_sclk, spi_cs_n, spi_mosi;
   logic        spi_miso, spi_miso_oe;
   logic [7:0]  reg_addr;
   logic [15:0] reg_wdat, reg_rdat;
   logic        reg_wr, reg_rd, reg_ack, busy;

   int checks = 0;
   int errors = 0;

   int ack_delay = 1;
   bit never_ack = 1'b0;

   int wr_pulses = 0, rd_pulses = 0, wr_cycles = 0, rd_cycles = 0;
   int stable_err = 0, both_err = 0;
   logic [7:0]  wr_addr_last = '0, rd_addr_last = '0;
   logic [15:0] wr_data_last = '0;
   logic wr_prev = 1'b0, rd_prev = 1'b0;

   int w0, r0, wc0, rc0;
   logic [31:0] rx;
   logic        extra;

   rtmc_spi_bridge dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .spi_sclk    (spi_sclk),
      .spi_cs_n    (spi_cs_n),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .spi_miso_oe (spi_miso_oe),
      .reg_addr    (reg_addr),
      .reg_wdat    (reg_wdat),
      .reg_wr      (reg_wr),
      .reg_rd      (reg_rd),
      .reg_rdat    (reg_rdat),
      .reg_ack     (reg_ack),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #10000000;
      $display("FAIL watchdog: run did not complete within the time limit");
      $fatal(1, "watchdog expired");
   end

   // Register-bus slave: acks ack_delay cycles after a request appears.
   initial begin
      logic [15:0] mem [256];
      int wait_cnt;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[0]   = 16'h0142;
      reg_ack  = 1'b0;
      reg_rdat = '0;
      wait_cnt = 0;
      forever begin
         @(negedge clk);
         if (!rst_n || !(reg_wr || reg_rd) || reg_ack) begin
            reg_ack  = 1'b0;
            wait_cnt = 0;
         end else begin
            wait_cnt++;
            if (!never_ack && wait_cnt >= ack_delay) begin
               reg_ack = 1'b1;
               if (reg_wr) mem[reg_addr] = reg_wdat;
               else        reg_rdat      = mem[reg_addr];
            end
         end
      end
   end

   always @(negedge clk) begin
      if (reg_wr) wr_cycles++;
      if (reg_rd) rd_cycles++;
      if (reg_wr && !wr_prev) begin
         wr_pulses++;
         wr_addr_last = reg_addr;
         wr_data_last = reg_wdat;
      end else if (reg_wr && (reg_addr != wr_addr_last || reg_wdat != wr_data_last)) begin
         stable_err++;
      end
      if (reg_rd && !rd_prev) begin
         rd_pulses++;
         rd_addr_last = reg_addr;
      end else if (reg_rd && reg_addr != rd_addr_last) begin
         stable_err++;
      end
      if (reg_wr && reg_rd) both_err++;
      wr_prev = reg_wr;
      rd_prev = reg_rd;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      w0  = wr_pulses;
      r0  = rd_pulses;
      wc0 = wr_cycles;
      rc0 = rd_cycles;
   endtask

   task automatic spi_xfer(input logic [31:0] word, input int nbits, input bit raise_cs,
                           output logic [31:0] rx_word, output logic extra_nz);
      rx_word  = '0;
      extra_nz = 1'b0;
      @(negedge clk);
      spi_cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = (i < 32) ? word[5'(31 - i)] : 1'b1;
         repeat (HALF) @(negedge clk);
         if (i < 32) rx_word = {rx_word[30:0], spi_miso};
         else        extra_nz = extra_nz | spi_miso;
         spi_sclk = 1'b1;
         repeat (HALF) @(negedge clk);
         spi_sclk = 1'b0;
      end
      spi_mosi = 1'b0;
      if (raise_cs) begin
         repeat (HALF) @(negedge clk);
         spi_cs_n = 1'b1;
         repeat (2 * HALF) @(negedge clk);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      spi_sclk = 1'b0;
      spi_cs_n = 1'b1;
      spi_mosi = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_reg_wr",   32'(reg_wr), 32'd0);
      check("rst_reg_rd",   32'(reg_rd), 32'd0);
      check("rst_busy",     32'(busy), 32'd0);
      check("rst_miso",     32'(spi_miso), 32'd0);
      check("rst_miso_oe",  32'(spi_miso_oe), 32'd0);
      check("rst_reg_addr", 32'(reg_addr), 32'd0);
      check("rst_reg_wdat", 32'(reg_wdat), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Plain write
      ack_delay = 1;
      snap();
      spi_xfer(32'h0004_1234, 32, 1'b1, rx, extra);
      check("wr1_pulses",   32'(wr_pulses - w0), 32'd1);
      check("wr1_no_rd",    32'(rd_pulses - r0), 32'd0);
      check("wr1_cycles",   32'(wr_cycles - wc0), 32'd1);
      check("wr1_addr",     32'(wr_addr_last), 32'h04);
      check("wr1_data",     32'(wr_data_last), 32'h1234);
      check("wr1_miso",     rx, 32'h0);
      check("wr1_busy",     32'(busy), 32'd0);

      // Plain read from preloaded slave location 0
      snap();
      spi_xfer(32'h8000_0000, 32, 1'b1, rx, extra);
      check("rd1_pulses",   32'(rd_pulses - r0), 32'd1);
      check("rd1_no_wr",    32'(wr_pulses - w0), 32'd0);
      check("rd1_addr",     32'(rd_addr_last), 32'h00);
      check("rd1_miso",     rx, 32'h0000_0142);

      // Write aborted after 20 bits, then a normal write
      snap();
      spi_xfer(32'h0004_5555, 20, 1'b0, rx, extra);
      repeat (HALF) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("abort_busy",   32'(busy), 32'd0);
      repeat (HALF) @(negedge clk);
      check("abort_no_wr",  32'(wr_pulses - w0), 32'd0);
      snap();
      spi_xfer(32'h0007_00AB, 32, 1'b1, rx, extra);
      check("post_abort_pulses", 32'(wr_pulses - w0), 32'd1);
      check("post_abort_addr",   32'(wr_addr_last), 32'h07);
      check("post_abort_data",   32'(wr_data_last), 32'h00AB);

      // Slow slave: 5-cycle ack, write then read back
      ack_delay = 5;
      snap();
      spi_xfer(32'h0005_BEEF, 32, 1'b1, rx, extra);
      check("slow_wr_cycles", 32'(wr_cycles - wc0), 32'd5);
      check("slow_wr_addr",   32'(wr_addr_last), 32'h05);
      check("slow_wr_data",   32'(wr_data_last), 32'hBEEF);
      snap();
      spi_xfer(32'h8005_0000, 32, 1'b1, rx, extra);
      check("slow_rd_cycles", 32'(rd_cycles - rc0), 32'd5);
      check("slow_rd_addr",   32'(rd_addr_last), 32'h05);
      check("slow_rd_miso",   rx, 32'h0000_BEEF);
      check("req_stable",     32'(stable_err), 32'd0);
      check("no_wr_rd_overlap", 32'(both_err), 32'd0);

      // Over-long frames: 40 SCLK pulses
      ack_delay = 1;
      snap();
      spi_xfer(32'h0006_CAFE, 40, 1'b1, rx, extra);
      check("long_wr_pulses", 32'(wr_pulses - w0), 32'd1);
      check("long_wr_addr",   32'(wr_addr_last), 32'h06);
      check("long_wr_data",   32'(wr_data_last), 32'hCAFE);
      check("long_wr_extra_miso", 32'(extra), 32'd0);
      snap();
      spi_xfer(32'h8006_0000, 40, 1'b1, rx, extra);
      check("long_rd_pulses", 32'(rd_pulses - r0), 32'd1);
      check("long_rd_miso",   rx, 32'h0000_CAFE);
      check("long_rd_extra_miso", 32'(extra), 32'd0);

      // Reset in the middle of a write frame
      snap();
      spi_xfer(32'h0002_7777, 20, 1'b0, rx, extra);
      check("mid_busy", 32'(busy), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy",    32'(busy), 32'd0);
      check("mid_rst_miso_oe", 32'(spi_miso_oe), 32'd0);
      check("mid_rst_reg_wr",  32'(reg_wr), 32'd0);
      spi_cs_n = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (HALF) @(negedge clk);
      check("mid_rst_no_wr", 32'(wr_pulses - w0), 32'd0);
      snap();
      spi_xfer(32'h0002_7777, 32, 1'b1, rx, extra);
      check("post_rst_pulses", 32'(wr_pulses - w0), 32'd1);
      check("post_rst_addr",   32'(wr_addr_last), 32'h02);
      check("post_rst_data",   32'(wr_data_last), 32'h7777);

`ifdef RTMC_SPI_TIMEOUT_EN
      // Silent slave: read times out, then sticky flag seen once in the header
      never_ack = 1'b1;
      snap();
      spi_xfer(32'h8009_0000, 32, 1'b1, rx, extra);
      never_ack = 1'b0;
      check("to_rd_cycles", 32'(rd_cycles - rc0), 32'd15);
      check("to_rd_addr",   32'(rd_addr_last), 32'h09);
      check("to_rd_miso",   rx, 32'h0000_DEAD);
      spi_xfer(32'h8000_0000, 32, 1'b1, rx, extra);
      check("to_flag_set",  rx, 32'h8000_0142);
      spi_xfer(32'h8000_0000, 32, 1'b1, rx, extra);
      check("to_flag_clr",  rx, 32'h0000_0142);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
